// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: redirect select encoding,
// fetch state encoding and the default bubble instruction.
package cpu_pkg;

   // redirect_sel encoding driven by the control-flow resolving stage
   localparam logic [1:0] SEL_SEQ = 2'b00;  // restart at redirect_pc_4
   localparam logic [1:0] SEL_BR  = 2'b01;  // pc_4 + (imm << 2)
   localparam logic [1:0] SEL_J   = 2'b10;  // region-relative jump
   localparam logic [1:0] SEL_JR  = 2'b11;  // register jump

   // Instruction-memory handshake state
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } fetch_state_t;

   // Bubble presented to decode when IF/ID holds nothing
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target computation for sequential restart, branch, jump and
// register jump. Purely combinational.
module pc_target_calc
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] pc_4,
   input  logic [XLEN-1:0] imm,
   input  logic [25:0]     field,
   input  logic [XLEN-1:0] reg_val,
   output logic [XLEN-1:0] target
);

   // Jumps keep the top bits of pc_4 and replace the low 28 bits
   localparam logic [XLEN-1:0] REGION_MASK = {{(XLEN-28){1'b1}}, 28'h0};
   localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

   // Select the redirect target; masks keep every input bit in use
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves target unassigned (no latch).
      target = pc_4;
      case (sel)
         SEL_SEQ: target = pc_4;
         SEL_BR:  target = pc_4 + (imm << 2);
         SEL_J:   target = (pc_4 & REGION_MASK) | XLEN'({field, 2'b00});
         SEL_JR:  target = reg_val & ALIGN_MASK;
         default: target = pc_4;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, variable-latency imem req/ack
// handshake, two-entry IF/ID buffer (output register + skid) and
// redirect/flush handling.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0]     NOP      = NOP_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [1:0]      redirect_sel,
   input  logic [XLEN-1:0] redirect_pc_4,
   input  logic [XLEN-1:0] redirect_imm,
   input  logic [25:0]     redirect_field,
   input  logic [XLEN-1:0] redirect_reg,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_4,
   output logic [31:0]     id_inst
);

   localparam logic [XLEN-1:0] WORD = XLEN'(4);

   fetch_state_t    state;
   logic            kill;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] target;

   logic [31:0]     id_inst_q;
   logic            skid_valid;
   logic [XLEN-1:0] skid_pc;
   logic [31:0]     skid_inst;

   logic            issue;
   logic            complete;
   logic            land;
   logic            id_free;

   pc_target_calc #(.XLEN(XLEN)) u_target (
      .sel     (redirect_sel),
      .pc_4    (redirect_pc_4),
      .imm     (redirect_imm),
      .field   (redirect_field),
      .reg_val (redirect_reg),
      .target  (target)
   );

   // Request handshake: a held request in BUSY, a fresh one in IDLE when the skid has room
   assign imem_req  = !rst && ((state == BUSY) || (!redirect && !skid_valid));
   assign imem_addr = (state == BUSY) ? req_addr : pc;
   assign issue     = (state == IDLE) && imem_req;
   assign complete  = imem_req && imem_ack;
   assign land      = complete && !kill && !redirect;
   assign id_free   = !id_valid || id_ready;

   // Decode sees a bubble whenever IF/ID is empty
   assign id_inst   = id_valid ? id_inst_q : NOP;

   // PC, handshake state and the kill flag for squashed in-flight requests
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (rst) begin
         pc       <= RESET_PC;
         req_addr <= '0;
         state    <= IDLE;
         kill     <= 1'b0;
      end else begin
         if (issue)
            req_addr <= pc;

         if (redirect)
            pc <= target;
         else if (issue)
            pc <= pc + WORD;

         case (state)
            IDLE: begin
               if (issue && !imem_ack)
                  state <= BUSY;
            end
            BUSY: begin
               if (imem_ack) begin
                  state <= IDLE;
                  kill  <= 1'b0;
               end else if (redirect) begin
                  kill  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // IF/ID output register plus skid; IF/ID is always the older entry
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: payload registers are reset too so the outputs read 0/NOP right after reset.
         id_valid   <= 1'b0;
         id_pc      <= '0;
         id_pc_4    <= '0;
         id_inst_q  <= NOP;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_inst  <= NOP;
      end else if (redirect) begin
         id_valid   <= 1'b0;
         skid_valid <= 1'b0;
      end else if (id_free) begin
         if (skid_valid) begin
            id_valid   <= 1'b1;
            id_pc      <= skid_pc;
            id_pc_4    <= skid_pc + WORD;
            id_inst_q  <= skid_inst;
            skid_valid <= land;
            if (land) begin
               skid_pc   <= imem_addr;
               skid_inst <= imem_rdata;
            end
         end else if (land) begin
            id_valid  <= 1'b1;
            id_pc     <= imem_addr;
            id_pc_4   <= imem_addr + WORD;
            id_inst_q <= imem_rdata;
         end else begin
            id_valid  <= 1'b0;
         end
      end else if (land) begin
         skid_valid <= 1'b1;
         skid_pc    <= imem_addr;
         skid_inst  <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model of the
// fetch stream, a randomized-latency memory and randomized decode stalls
// and redirects, plus directed redirect and reset scenarios.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TB_NOP   = 32'h0BAD_F00D;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [1:0]  redirect_sel;
   logic [31:0] redirect_pc_4;
   logic [31:0] redirect_imm;
   logic [25:0] redirect_field;
   logic [31:0] redirect_reg;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_pc_4;
   logic [31:0] id_inst;

   fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .NOP(TB_NOP)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect       (redirect),
      .redirect_sel   (redirect_sel),
      .redirect_pc_4  (redirect_pc_4),
      .redirect_imm   (redirect_imm),
      .redirect_field (redirect_field),
      .redirect_reg   (redirect_reg),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_pc_4        (id_pc_4),
      .id_inst        (id_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: the fetch stream as a program counter, one outstanding
   // request and a FIFO of fetched-but-unconsumed instructions (max 2).
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t      m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_req_addr;
   bit          m_busy;
   bit          m_kill;

   // Memory model state and stimulus knobs
   bit mem_busy;
   int mem_cnt, mem_lat;
   int min_lat, max_lat, p_redir, p_ready, p_rst;
   bit spur;

   bit          g_issued;
   logic [31:0] g_issue_addr;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic [31:0] ref_target(input logic [1:0] sel, input logic [31:0] pc4,
                                              input logic [31:0] imm, input logic [25:0] fld,
                                              input logic [31:0] rg);
      case (sel)
         2'd0:    return pc4;
         2'd1:    return pc4 + imm * 32'd4;
         2'd2:    return (pc4 & 32'hF000_0000) | ({6'd0, fld} * 32'd4);
         default: return rg & 32'hFFFF_FFFC;
      endcase
   endfunction

   task automatic reset_model();
      m_pc       = RESET_PC;
      m_req_addr = '0;
      m_busy     = 0;
      m_kill     = 0;
      m_q.delete();
   endtask

   // One clock: drive memory, compare outputs, advance the model
   task automatic step();
      logic        exp_req;
      logic [31:0] exp_addr;
      bit          issue, done;
      entry_t      e;
      exp_req  = !rst && (m_busy || (!redirect && m_q.size() < 2));
      exp_addr = m_busy ? m_req_addr : m_pc;
      if (exp_req) begin
         if (!mem_busy) begin
            mem_lat = int'($urandom_range(max_lat, min_lat));
            mem_cnt = 0;
         end
         imem_ack = (mem_cnt >= mem_lat);
      end else begin
         imem_ack = spur && ($urandom_range(1, 0) == 1);
      end
      imem_rdata = exp_req ? mem_data(exp_addr) : $urandom;
      #1;
      check("imem_req", imem_req, exp_req);
      if (exp_req) check("imem_addr", imem_addr, exp_addr);
      check("id_valid", id_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         check("id_pc", id_pc, m_q[0].pc);
         check("id_pc_4", id_pc_4, m_q[0].pc + 32'd4);
         check("id_inst", id_inst, m_q[0].inst);
      end else begin
         check("id_inst_nop", id_inst, TB_NOP);
      end
      issue        = exp_req && !m_busy;
      g_issued     = issue;
      g_issue_addr = imem_addr;
      done         = exp_req && imem_ack;
      @(posedge clk);
      if (exp_req && !imem_ack) begin
         mem_busy = 1;
         mem_cnt++;
      end else begin
         mem_busy = 0;
      end
      if (rst) begin
         reset_model();
      end else begin
         if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
         if (redirect) begin
            m_q.delete();
            m_pc = ref_target(redirect_sel, redirect_pc_4, redirect_imm, redirect_field, redirect_reg);
            if (m_busy) begin
               if (done) begin
                  m_busy = 0;
                  m_kill = 0;
               end else begin
                  m_kill = 1;
               end
            end
         end else begin
            if (done && !m_kill) begin
               e.pc   = exp_addr;
               e.inst = mem_data(exp_addr);
               m_q.push_back(e);
            end
            if (issue) begin
               m_req_addr = m_pc;
               m_pc       = m_pc + 32'd4;
            end
            if (done) begin
               m_busy = 0;
               m_kill = 0;
            end else if (issue) begin
               m_busy = 1;
            end
         end
      end
      #1;
   endtask

   task automatic rand_inputs();
      logic [15:0] imm16;
      rst            = ($urandom_range(99, 0) < p_rst);
      redirect       = ($urandom_range(99, 0) < p_redir);
      redirect_sel   = 2'($urandom);
      redirect_pc_4  = $urandom & 32'hFFFF_FFFC;
      imm16          = 16'($urandom);
      redirect_imm   = {{16{imm16[15]}}, imm16};
      redirect_field = 26'($urandom);
      redirect_reg   = $urandom;
      id_ready       = ($urandom_range(99, 0) < p_ready);
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (!m_busy && n < 20) begin
         step();
         n++;
      end
      check({tag, "_reached_busy"}, 64'(m_busy), 64'd1);
   endtask

   task automatic wait_issue(input string tag, input logic [31:0] exp_addr);
      int n = 0;
      do begin
         step();
         n++;
      end while (!g_issued && n < 30);
      check({tag, "_issued"}, 64'(g_issued), 64'd1);
      check({tag, "_addr"}, g_issue_addr, exp_addr);
   endtask

   task automatic redirect_case(input string tag, input logic [1:0] sel, input logic [31:0] pc4,
                                input logic [31:0] imm, input logic [25:0] fld,
                                input logic [31:0] rg, input logic [31:0] exp_addr);
      wait_busy(tag);
      redirect       = 1'b1;
      redirect_sel   = sel;
      redirect_pc_4  = pc4;
      redirect_imm   = imm;
      redirect_field = fld;
      redirect_reg   = rg;
      step();
      redirect = 1'b0;
      wait_issue(tag, exp_addr);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_sel = SEL_SEQ;
      redirect_pc_4 = '0; redirect_imm = '0; redirect_field = '0; redirect_reg = '0;
      imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b1;
      min_lat = 0; max_lat = 0; p_redir = 0; p_ready = 100; p_rst = 0; spur = 0;
      mem_busy = 0; mem_cnt = 0; mem_lat = 0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      step();
      check("rst_id_pc", id_pc, 32'd0);
      check("rst_id_pc_4", id_pc_4, 32'd0);
      rst = 1'b0;

      // Zero-wait memory, decode always ready: one fetch per cycle
      for (int i = 0; i < 6; i++) begin
         step();
         check("zw_addr", g_issue_addr, 32'(4 * i));
      end

      // Decode stall: two instructions buffered, request dropped
      id_ready = 1'b0;
      repeat (5) step();
      check("bp_req_low", imem_req, 1'b0);
      check("bp_valid", id_valid, 1'b1);
      id_ready = 1'b1;
      repeat (6) step();

      // Fixed 3-cycle latency
      min_lat = 3; max_lat = 3;
      repeat (16) step();

      // Redirects while a request is in flight
      redirect_case("br",  SEL_BR,  32'h0000_0100, 32'hFFFF_FFFE, 26'd0,        32'd0,     32'h0000_00F8);
      redirect_case("j",   SEL_J,   32'h1000_0004, 32'd0,         26'h000_0040, 32'd0,     32'h1000_0100);
      redirect_case("jr",  SEL_JR,  32'h0000_0040, 32'd0,         26'd0,        32'h203,   32'h0000_0200);
      redirect_case("seq", SEL_SEQ, 32'h0000_0400, 32'd0,         26'd0,        32'd0,     32'h0000_0400);

      // Reset mid-transfer with stray acks around it
      wait_busy("rst_mid");
      spur = 1;
      rst  = 1'b1;
      step();
      rst  = 1'b0;
      wait_issue("rst_mid", RESET_PC);

      // Randomized traffic: variable latency, stalls, redirects, resets
      min_lat = 0; max_lat = 3; p_redir = 8; p_ready = 60; p_rst = 1;
      for (int i = 0; i < 1500; i++) begin
         rand_inputs();
         step();
      end

      // Randomized traffic against zero-wait memory
      max_lat = 0; p_redir = 5; p_ready = 70;
      for (int i = 0; i < 500; i++) begin
         rand_inputs();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
